gc_evaluator: RTL and testbench

GC_EVALUATOR -- requirements
Module: gc_evaluator

---
 rtl/gc_evaluator.sv | 146 ++++++++++++++
 tb/tb_gc_evaluator.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gc_evaluator.sv
// Garbled-circuit evaluator: walks a netlist gate by gate, free-XOR for XOR gates and half-gate AND
// using a streamed garbled table and an external hash engine. Define GC_EVAL_OUTSTREAM_EN for a result stream.
module gc_evaluator #(
  parameter int S          = 20,
  parameter int K          = 128,
  // number of circuit input wires; gate outputs follow them in the wire numbering
  parameter int NUM_INPUTS = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [S-1:0]   num_gates,
  output logic           done,
  output logic           error,
  output logic [S-1:0]   gid,
  input  logic [S-1:0]   in0,
  input  logic [S-1:0]   in1,
  input  logic [3:0]     g_logic,
  output logic [S-1:0]   lbl_rd_addr0,
  output logic [S-1:0]   lbl_rd_addr1,
  input  logic [K-1:0]   lbl_rd_data0,
  input  logic [K-1:0]   lbl_rd_data1,
  output logic           lbl_wr_en,
  output logic [S-1:0]   lbl_wr_addr,
  output logic [K-1:0]   lbl_wr_data,
  input  logic           gt_valid,
  output logic           gt_ready,
  input  logic [2*K-1:0] gt_data,
  output logic           h_req_valid,
  input  logic           h_req_ready,
  output logic [K-1:0]   h_req_lbl0,
  output logic [K-1:0]   h_req_lbl1,
  output logic [S:0]     h_req_tweak0,
  output logic [S:0]     h_req_tweak1,
`ifdef GC_EVAL_OUTSTREAM_EN
  output logic           out_valid,
  output logic [S-1:0]   out_gid,
  output logic [K-1:0]   out_label,
`endif
  input  logic           h_rsp_valid,
  input  logic [K-1:0]   h_rsp_data0,
  input  logic [K-1:0]   h_rsp_data1
);

  localparam logic [3:0] XOR_TT = 4'b0110;
  localparam logic [3:0] AND_TT = 4'b1000;

  typedef enum logic [3:0] {
    IDLE, FETCH, READ, WAIT_GT, HASH_REQ, HASH_RSP, WRITE, DONE, ERR
  } state_t;

  state_t       state, state_next;
  logic [S-1:0] ng;
  logic [K-1:0] wa, wb, wc, tg, te;
  logic         last_gate;

  assign last_gate = (gid == ng - S'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE, ERR: if (start) state_next = (num_gates == '0) ? DONE : FETCH;
      FETCH:     state_next = READ;
      READ: begin
        if (g_logic == XOR_TT)      state_next = WRITE;
        else if (g_logic == AND_TT) state_next = WAIT_GT;
        else                        state_next = ERR;
      end
      WAIT_GT:   if (gt_valid)    state_next = HASH_REQ;
      HASH_REQ:  if (h_req_ready) state_next = HASH_RSP;
      HASH_RSP:  if (h_rsp_valid) state_next = WRITE;
      WRITE:     state_next = last_gate ? DONE : FETCH;
      DONE:      state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  // Half-gate AND: the select bits are the lsb of each input label (point-and-permute).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gid <= '0;
      ng  <= '0;
      wa  <= '0;
      wb  <= '0;
      wc  <= '0;
      tg  <= '0;
      te  <= '0;
    end else begin
      case (state)
        IDLE, ERR: begin
          if (start) begin
            ng  <= num_gates;
            gid <= '0;
          end
        end
        READ: begin
          wa <= lbl_rd_data0;
          wb <= lbl_rd_data1;
          if (g_logic == XOR_TT) wc <= lbl_rd_data0 ^ lbl_rd_data1;
        end
        WAIT_GT: begin
          if (gt_valid) begin
            tg <= gt_data[K-1:0];
            te <= gt_data[2*K-1:K];
          end
        end
        HASH_RSP: begin
          if (h_rsp_valid)
            wc <= h_rsp_data0 ^ (wa[0] ? tg : '0) ^ h_rsp_data1 ^ (wb[0] ? (te ^ wa) : '0);
        end
        WRITE: begin
          if (!last_gate) gid <= gid + S'(1);
        end
        default: ;
      endcase
    end
  end

  assign done         = (state == DONE);
  assign error        = (state == ERR);
  assign gt_ready     = (state == WAIT_GT);
  assign h_req_valid  = (state == HASH_REQ);
  assign lbl_wr_en    = (state == WRITE);

  assign lbl_rd_addr0 = in0 + S'(2);
  assign lbl_rd_addr1 = in1 + S'(2);
  assign lbl_wr_addr  = S'(NUM_INPUTS) + S'(2) + gid;
  assign lbl_wr_data  = wc;

  assign h_req_lbl0   = wa;
  assign h_req_lbl1   = wb;
  assign h_req_tweak0 = {gid, 1'b0};
  assign h_req_tweak1 = {gid, 1'b1};

`ifdef GC_EVAL_OUTSTREAM_EN
  assign out_valid = lbl_wr_en;
  assign out_gid   = gid;
  assign out_label = wc;
`endif

endmodule

// File: tb/tb_gc_evaluator.sv
// Scoreboard bench for gc_evaluator: a wire-level reference model queues expected writes and hash
// requests; a negedge environment process plays RAM, table source and hash engine and compares.
module tb_gc_evaluator;
  localparam int S = 20, K = 128, NIN = 4, MAXG = 32;

  logic clk, rst, start, done, error;
  logic [S-1:0] num_gates, gid, in0, in1;
  logic [3:0] g_logic;
  logic [S-1:0] lbl_rd_addr0, lbl_rd_addr1, lbl_wr_addr;
  logic [K-1:0] lbl_rd_data0, lbl_rd_data1, lbl_wr_data;
  logic lbl_wr_en, gt_valid, gt_ready;
  logic [2*K-1:0] gt_data;
  logic h_req_valid, h_req_ready, h_rsp_valid;
  logic [K-1:0] h_req_lbl0, h_req_lbl1, h_rsp_data0, h_rsp_data1;
  logic [S:0] h_req_tweak0, h_req_tweak1;
`ifdef GC_EVAL_OUTSTREAM_EN
  logic out_valid;
  logic [S-1:0] out_gid;
  logic [K-1:0] out_label;
`endif

  typedef struct { logic [S-1:0] addr; logic [K-1:0] data; } wr_t;
  typedef struct { logic [K-1:0] l0; logic [K-1:0] l1; logic [S:0] t0; logic [S:0] t1; } req_t;

  wr_t  exp_wr[$];
  req_t exp_req[$];
  int   exp_err, errors = 0, checks = 0, done_seen;
  logic [K-1:0] ram [0:63];
  logic [S-1:0] net_in0 [MAXG];
  logic [S-1:0] net_in1 [MAXG];
  logic [3:0]   net_g [MAXG];
  logic [K-1:0] tab_tg [MAXG];
  logic [K-1:0] tab_te [MAXG];
  int  gt_delay = -1, req_delay = -1, rsp_delay = -1;
  bit  hash_fixed = 0, late_rsp = 0, rsp_pending = 0;
  logic [K-1:0] fix0, fix1;
  int  gt_idx;

  gc_evaluator #(.S(S), .K(K), .NUM_INPUTS(NIN)) dut (
    .clk(clk), .rst(rst), .start(start), .num_gates(num_gates), .done(done), .error(error),
    .gid(gid), .in0(in0), .in1(in1), .g_logic(g_logic),
    .lbl_rd_addr0(lbl_rd_addr0), .lbl_rd_addr1(lbl_rd_addr1),
    .lbl_rd_data0(lbl_rd_data0), .lbl_rd_data1(lbl_rd_data1),
    .lbl_wr_en(lbl_wr_en), .lbl_wr_addr(lbl_wr_addr), .lbl_wr_data(lbl_wr_data),
    .gt_valid(gt_valid), .gt_ready(gt_ready), .gt_data(gt_data),
    .h_req_valid(h_req_valid), .h_req_ready(h_req_ready),
    .h_req_lbl0(h_req_lbl0), .h_req_lbl1(h_req_lbl1),
    .h_req_tweak0(h_req_tweak0), .h_req_tweak1(h_req_tweak1),
`ifdef GC_EVAL_OUTSTREAM_EN
    .out_valid(out_valid), .out_gid(out_gid), .out_label(out_label),
`endif
    .h_rsp_valid(h_rsp_valid), .h_rsp_data0(h_rsp_data0), .h_rsp_data1(h_rsp_data1)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  assign in0     = net_in0[gid[4:0]];
  assign in1     = net_in1[gid[4:0]];
  assign g_logic = net_g[gid[4:0]];

  always @(posedge clk) begin
    lbl_rd_data0 <= ram[lbl_rd_addr0[5:0]];
    lbl_rd_data1 <= ram[lbl_rd_addr1[5:0]];
  end

  function automatic logic [K-1:0] hf(input logic [K-1:0] l, input logic [S:0] t);
    logic [K-1:0] m;
    m = {{(K-S-1){1'b0}}, t} * 128'h9E3779B97F4A7C15F39CC0605CEDC835;
    return {l[K-9:0], l[K-1:K-8]} ^ m ^ 128'h5A;
  endfunction

  function automatic logic [K-1:0] rnd();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic int pick(input int mode);
    return (mode >= 0) ? mode : int'($urandom_range(0, 3));
  endfunction

  task automatic checkOutput(input string name, input logic [K-1:0] act, input logic [K-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic failNow(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s", name);
  endtask

  // Reference: labels per wire index; free-XOR and half-gate AND straight from their definitions.
  task automatic buildModel(input int n);
    logic [K-1:0] lab [0:63];
    logic [K-1:0] a, b, c, h0, h1;
    logic [S:0] t0, t1;
    int ai;
    wr_t w;
    req_t r;
    exp_wr.delete();
    exp_req.delete();
    exp_err = -1;
    ai = 0;
    for (int i = 0; i < NIN; i++) lab[i] = ram[i+2];
    for (int g = 0; g < n; g++) begin
      a = lab[net_in0[g][5:0]];
      b = lab[net_in1[g][5:0]];
      if (net_g[g] == 4'b0110) c = a ^ b;
      else if (net_g[g] == 4'b1000) begin
        t0 = (S+1)'(2*g);
        t1 = (S+1)'(2*g + 1);
        r.l0 = a; r.l1 = b; r.t0 = t0; r.t1 = t1;
        exp_req.push_back(r);
        h0 = hash_fixed ? fix0 : hf(a, t0);
        h1 = hash_fixed ? fix1 : hf(b, t1);
        c = h0 ^ h1 ^ (a[0] ? tab_tg[ai] : '0) ^ (b[0] ? (tab_te[ai] ^ a) : '0);
        ai++;
      end else begin
        exp_err = g;
        break;
      end
      lab[NIN+g] = c;
      w.addr = S'(NIN + 2 + g);
      w.data = c;
      exp_wr.push_back(w);
    end
  endtask

  task automatic setupRandom(input int n, input bit xor_only);
    for (int w = 0; w < NIN; w++) ram[w+2] = rnd();
    for (int g = 0; g < n; g++) begin
      net_in0[g] = S'($urandom_range(0, NIN + g - 1));
      net_in1[g] = S'($urandom_range(0, NIN + g - 1));
      net_g[g]   = (xor_only || $urandom_range(0, 1) == 0) ? 4'b0110 : 4'b1000;
      tab_tg[g]  = rnd();
      tab_te[g]  = rnd();
    end
  endtask

  // Environment and monitor: everything sampled and driven on the falling edge.
  initial begin
    bit gt_armed = 0, req_armed = 0;
    int gt_wait = 0, req_wait = 0, rsp_cnt = 0;
    logic [K-1:0] nh0, nh1;
    wr_t w;
    gt_valid = 0; gt_data = '0; h_req_ready = 0;
    h_rsp_valid = 0; h_rsp_data0 = '0; h_rsp_data1 = '0;
    forever begin
      @(negedge clk);
      h_rsp_valid = 0;
      if (late_rsp) begin
        h_rsp_valid = 1; h_rsp_data0 = '1; h_rsp_data1 = '1;
        late_rsp = 0;
      end
      if (rst) begin
        gt_valid = 0; h_req_ready = 0; rsp_pending = 0; gt_armed = 0; req_armed = 0;
      end else begin
        if (done) done_seen++;
        if (lbl_wr_en) begin
          if (exp_wr.size() == 0) failNow("unexpected_write");
          else begin
            w = exp_wr.pop_front();
            checkOutput("wr_addr", lbl_wr_addr, w.addr);
            checkOutput("wr_data", lbl_wr_data, w.data);
`ifdef GC_EVAL_OUTSTREAM_EN
            checkOutput("out_valid", out_valid, 1);
            checkOutput("out_gid", out_gid, w.addr - S'(NIN + 2));
            checkOutput("out_label", out_label, w.data);
`endif
          end
          ram[lbl_wr_addr[5:0]] = lbl_wr_data;
        end
`ifdef GC_EVAL_OUTSTREAM_EN
        else checkOutput("out_valid_idle", out_valid, 0);
`endif
        if (rsp_pending) begin
          if (rsp_cnt == 0) begin
            h_rsp_valid = 1; h_rsp_data0 = nh0; h_rsp_data1 = nh1;
            rsp_pending = 0;
          end else rsp_cnt--;
        end
        if (gt_ready) begin
          if (!gt_armed) begin gt_armed = 1; gt_wait = pick(gt_delay); end
          if (gt_wait > 0) begin gt_wait--; gt_valid = 0; end
          else begin
            gt_valid = 1;
            gt_data  = {tab_te[gt_idx], tab_tg[gt_idx]};
            gt_idx++;
            gt_armed = 0;
          end
        end else gt_valid = 0;
        if (h_req_valid) begin
          if (exp_req.size() == 0) failNow("unexpected_hash_request");
          else begin
            checkOutput("req_lbl0", h_req_lbl0, exp_req[0].l0);
            checkOutput("req_lbl1", h_req_lbl1, exp_req[0].l1);
            checkOutput("req_tweak0", h_req_tweak0, exp_req[0].t0);
            checkOutput("req_tweak1", h_req_tweak1, exp_req[0].t1);
          end
          if (!req_armed) begin req_armed = 1; req_wait = pick(req_delay); end
          if (req_wait > 0) begin req_wait--; h_req_ready = 0; end
          else begin
            h_req_ready = 1;
            req_armed = 0;
            if (exp_req.size() != 0) void'(exp_req.pop_front());
            nh0 = hash_fixed ? fix0 : hf(h_req_lbl0, h_req_tweak0);
            nh1 = hash_fixed ? fix1 : hf(h_req_lbl1, h_req_tweak1);
            rsp_pending = 1;
            rsp_cnt = pick(rsp_delay);
          end
        end else h_req_ready = 0;
      end
    end
  end

  task automatic applyStimulus(input int n, input int exp_cyc);
    int cyc;
    bit finished;
    buildModel(n);
    gt_idx = 0;
    done_seen = 0;
    @(negedge clk);
    num_gates = S'(n);
    start = 1;
    @(posedge clk);
    #1 start = 0;
    checkOutput("error_clear_on_start", error, 0);
    cyc = 0;
    finished = 0;
    while (!finished && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (done || error) finished = 1;
    end
    if (!finished) failNow("timeout_waiting_done");
    else if (exp_err < 0) begin
      checkOutput("done_pulse", done, 1);
      if (exp_cyc >= 0) checkOutput("latency", cyc, exp_cyc);
      @(negedge clk);
      checkOutput("done_one_cycle", done, 0);
    end else begin
      checkOutput("error_flag", error, 1);
      checkOutput("error_gid", gid, exp_err);
      @(negedge clk);
      checkOutput("error_sticky", error, 1);
    end
    checkOutput("writes_left", exp_wr.size(), 0);
    checkOutput("requests_left", exp_req.size(), 0);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_done"}, done, 0);
    checkOutput({tag, "_error"}, error, 0);
    checkOutput({tag, "_gt_ready"}, gt_ready, 0);
    checkOutput({tag, "_h_req_valid"}, h_req_valid, 0);
    checkOutput({tag, "_lbl_wr_en"}, lbl_wr_en, 0);
    checkOutput({tag, "_gid"}, gid, 0);
  endtask

  initial begin
    int cyc;
    rst = 1; start = 0; num_gates = '0; fix0 = '0; fix1 = '0;
    for (int i = 0; i < 64; i++) ram[i] = '0;
    for (int g = 0; g < MAXG; g++) begin
      net_in0[g] = '0; net_in1[g] = '0; net_g[g] = 4'b0110; tab_tg[g] = '0; tab_te[g] = '0;
    end
    ram[0] = 128'h0;
    ram[1] = 128'h1;
    #1 checkResetOutputs("reset");
    repeat (3) @(negedge clk);
    rst = 0;

    ram[2] = 128'h0F; ram[3] = 128'hF0;
    net_in0[0] = 0; net_in1[0] = 1; net_g[0] = 4'b0110;
    applyStimulus(1, 4);
    checkOutput("xor_vector", ram[NIN+2], 128'hFF);

    hash_fixed = 1;
    ram[2] = 128'h2; ram[3] = 128'h4; net_g[0] = 4'b1000;
    fix0 = 128'hA; fix1 = 128'h5; tab_tg[0] = rnd(); tab_te[0] = rnd();
    applyStimulus(1, -1);
    checkOutput("and_vector_s00", ram[NIN+2], 128'hF);

    ram[2] = 128'h1; ram[3] = 128'h3;
    fix0 = '0; fix1 = '0; tab_tg[0] = 128'h10; tab_te[0] = 128'h20;
    applyStimulus(1, -1);
    checkOutput("and_vector_s11", ram[NIN+2], 128'h31);

    gt_delay = 4; req_delay = 3; rsp_delay = 2;
    ram[NIN+2] = '0;
    applyStimulus(1, -1);
    checkOutput("and_backpressure", ram[NIN+2], 128'h31);
    hash_fixed = 0; gt_delay = -1; req_delay = -1; rsp_delay = -1;

    applyStimulus(0, 1);

    setupRandom(5, 1);
    applyStimulus(5, 16);

    for (int r = 0; r < 6; r++) begin
      int n;
      n = int'($urandom_range(1, 12));
      setupRandom(n, 0);
      applyStimulus(n, -1);
    end

    setupRandom(4, 0);
    net_g[2] = 4'b1110;
    applyStimulus(4, -1);
    setupRandom(3, 0);
    applyStimulus(3, -1);

    // Reset while the hash response is still pending; the late response must be dropped.
    setupRandom(1, 0);
    net_g[0] = 4'b1000;
    gt_delay = 0; req_delay = 0; rsp_delay = 6;
    buildModel(1);
    gt_idx = 0;
    done_seen = 0;
    @(negedge clk);
    num_gates = S'(1);
    start = 1;
    @(posedge clk);
    #1 start = 0;
    cyc = 0;
    while (!rsp_pending && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    if (!rsp_pending) failNow("timeout_waiting_hash_request");
    repeat (2) @(negedge clk);
    #2 rst = 1;
    exp_wr.delete();
    exp_req.delete();
    #1 checkResetOutputs("midrun_reset");
    repeat (2) @(negedge clk);
    rst = 0;
    @(negedge clk);
    #1 late_rsp = 1;
    repeat (8) @(negedge clk);
    checkOutput("no_done_after_reset", done_seen, 0);
    checkOutput("idle_after_late_rsp", h_req_valid, 0);
    checkOutput("gid_after_late_rsp", gid, 0);
    gt_delay = -1; req_delay = -1; rsp_delay = -1;

    setupRandom(3, 0);
    applyStimulus(3, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
